// File: rtl/cp0_unit.sv
// CP0 register file plus commit-time exception, interrupt and ERET resolution.
// Optional feature macro: CP0_TIMER_EN adds the Count/Compare timer and Cause.TI.
module cp0_unit #(
    parameter int unsigned EXT_INT_NUM = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COUNT_DIV   = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'hbfc00380
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [EXT_INT_NUM-1:0] ext_int,
    input  logic                   commit_valid,
    input  logic                   commit_ex,
    input  logic [4:0]             commit_exccode,
    input  logic                   commit_bd,
    input  logic [31:0]            commit_pc,
    input  logic [31:0]            commit_badvaddr,
    input  logic                   commit_eret,
    input  logic                   mtc0_we,
    input  logic [7:0]             mtc0_addr,
    input  logic [31:0]            mtc0_wdata,
    input  logic [7:0]             mfc0_addr,
    output logic [31:0]            mfc0_rdata,
    output logic                   int_pending,
    output logic                   flush,
    output logic [31:0]            flush_pc
);
    localparam logic [7:0] AddrBadVAddr = 8'h40;
    localparam logic [7:0] AddrCount    = 8'h48;
    localparam logic [7:0] AddrCompare  = 8'h58;
    localparam logic [7:0] AddrStatus   = 8'h60;
    localparam logic [7:0] AddrCause    = 8'h68;
    localparam logic [7:0] AddrEpc      = 8'h70;
    localparam int unsigned SyncW = SYNC_STAGES * EXT_INT_NUM;

    logic [31:0]      badvaddr_q, badvaddr_d;
    logic [31:0]      epc_q, epc_d;
    logic [7:0]       im_q, im_d;
    logic             exl_q, exl_d;
    logic             ie_q, ie_d;
    logic             bd_q, bd_d;
    logic [4:0]       exccode_q, exccode_d;
    logic [1:0]       ip_sw_q, ip_sw_d;
    logic [5:0]       ip_hw_q, ip_hw_d;
    logic [SyncW-1:0] sync_q;

    logic             ti;
    logic [31:0]      count_rd, compare_rd;
    logic [7:0]       ip;
    logic [31:0]      status_rd, cause_rd;
    logic             take_int, take_ex, do_eret, mtc0_ok;
    logic [4:0]       exc_code;

    // Cause.IP[7] is shared between ext_int[5] and the timer.
    assign ip          = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};
    assign int_pending = (|(ip & im_q)) & ie_q & ~exl_q;

    assign take_int = commit_valid & int_pending;
    assign take_ex  = commit_valid & (commit_ex | take_int);
    assign exc_code = take_int ? 5'h00 : commit_exccode;
    assign do_eret  = commit_valid & commit_eret & ~take_ex;
    assign mtc0_ok  = commit_valid & mtc0_we & ~take_ex;
    assign flush    = take_ex | do_eret;
    assign flush_pc = do_eret ? epc_q : EXC_VECTOR;

    assign status_rd = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_rd  = {bd_q, ti, 14'd0, ip, 1'b0, exccode_q, 2'b00};

    always_comb begin
        mfc0_rdata = 32'd0;
        case (mfc0_addr)
            AddrBadVAddr: mfc0_rdata = badvaddr_q;
            AddrCount:    mfc0_rdata = count_rd;
            AddrCompare:  mfc0_rdata = compare_rd;
            AddrStatus:   mfc0_rdata = status_rd;
            AddrCause:    mfc0_rdata = cause_rd;
            AddrEpc:      mfc0_rdata = epc_q;
            default:      mfc0_rdata = 32'd0;
        endcase
    end

    // Sync chain is a flat shift register; the oldest stage feeds Cause.IP.
    always_comb begin
        ip_hw_d = 6'd0;
        ip_hw_d[EXT_INT_NUM-1:0] = sync_q[SyncW-1 -: EXT_INT_NUM];
    end

    always_comb begin
        badvaddr_d = badvaddr_q;
        epc_d      = epc_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;
        if (take_ex) begin
            exl_d     = 1'b1;
            exccode_d = exc_code;
            if (!exl_q) begin
                epc_d = commit_bd ? commit_pc - 32'd4 : commit_pc;
                bd_d  = commit_bd;
            end
            if (exc_code == 5'h04 || exc_code == 5'h05) begin
                badvaddr_d = commit_badvaddr;
            end
        end else if (mtc0_ok) begin
            case (mtc0_addr)
                AddrStatus: begin
                    im_d  = mtc0_wdata[15:8];
                    exl_d = mtc0_wdata[1];
                    ie_d  = mtc0_wdata[0];
                end
                AddrCause: ip_sw_d = mtc0_wdata[9:8];
                AddrEpc:   epc_d   = mtc0_wdata;
                default:   ;
            endcase
        end
        if (do_eret) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            badvaddr_q <= 32'd0;
            epc_q      <= 32'd0;
            im_q       <= 8'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exccode_q  <= 5'd0;
            ip_sw_q    <= 2'd0;
            ip_hw_q    <= 6'd0;
            sync_q     <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            epc_q      <= epc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
            sync_q     <= SyncW'({sync_q, ext_int});
        end
    end

`ifdef CP0_TIMER_EN
    localparam int unsigned DivW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(COUNT_DIV - 1);

    logic [31:0]     count_q, count_d, compare_q, compare_d;
    logic [DivW-1:0] div_q, div_d;
    logic            ti_q, ti_d;
    logic            count_wr, compare_wr, count_tick;

    assign count_wr   = mtc0_ok && (mtc0_addr == AddrCount);
    assign compare_wr = mtc0_ok && (mtc0_addr == AddrCompare);
    assign count_tick = !count_wr && (div_q == DivMax);

    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        div_d     = div_q;
        ti_d      = ti_q;
        if (count_wr) begin
            count_d = mtc0_wdata;
            div_d   = '0;
        end else if (count_tick) begin
            count_d = count_q + 32'd1;
            div_d   = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
        if (count_tick && (count_d == compare_q)) begin
            ti_d = 1'b1;
        end
        // A Compare write clears TI even if a match happens in the same cycle.
        if (compare_wr) begin
            compare_d = mtc0_wdata;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            div_q     <= '0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            div_q     <= div_d;
            ti_q      <= ti_d;
        end
    end

    assign ti         = ti_q;
    assign count_rd   = count_q;
    assign compare_rd = compare_q;
`else
    assign ti         = 1'b0;
    assign count_rd   = 32'd0;
    assign compare_rd = 32'd0;
`endif

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed vector table, hand-written corner sequences
// and a randomized run against a word-level reference model.
module tb_cp0_unit;
    localparam int EXT_INT_NUM = 6;
    localparam int SYNC_STAGES = 2;
    localparam int COUNT_DIV   = 2;
    localparam logic [31:0] VEC = 32'hbfc00380;
    localparam logic [7:0] A_BVA = 8'h40, A_CNT = 8'h48, A_CMP = 8'h58;
    localparam logic [7:0] A_ST = 8'h60, A_CA = 8'h68, A_EPC = 8'h70;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [5:0]  ext_int = 6'd0;
    logic        commit_valid, commit_ex, commit_bd, commit_eret, mtc0_we;
    logic [4:0]  commit_exccode;
    logic [31:0] commit_pc, commit_badvaddr, mtc0_wdata;
    logic [7:0]  mtc0_addr, mfc0_addr;
    logic [31:0] mfc0_rdata, flush_pc;
    logic        int_pending, flush;

    cp0_unit #(
        .EXT_INT_NUM(EXT_INT_NUM),
        .SYNC_STAGES(SYNC_STAGES),
        .COUNT_DIV  (COUNT_DIV),
        .EXC_VECTOR (VEC)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ext_int        (ext_int),
        .commit_valid   (commit_valid),
        .commit_ex      (commit_ex),
        .commit_exccode (commit_exccode),
        .commit_bd      (commit_bd),
        .commit_pc      (commit_pc),
        .commit_badvaddr(commit_badvaddr),
        .commit_eret    (commit_eret),
        .mtc0_we        (mtc0_we),
        .mtc0_addr      (mtc0_addr),
        .mtc0_wdata     (mtc0_wdata),
        .mfc0_addr      (mfc0_addr),
        .mfc0_rdata     (mfc0_rdata),
        .int_pending    (int_pending),
        .flush          (flush),
        .flush_pc       (flush_pc)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        commit_valid = 0; commit_ex = 0; commit_exccode = 0; commit_bd = 0;
        commit_pc = 0; commit_badvaddr = 0; commit_eret = 0;
        mtc0_we = 0; mtc0_addr = 0; mtc0_wdata = 0;
    endtask

    task automatic drive(input logic v, input logic ex, input logic [4:0] code, input logic bd,
                         input logic [31:0] pc, input logic [31:0] bva, input logic er,
                         input logic we, input logic [7:0] addr, input logic [31:0] wd);
        commit_valid = v; commit_ex = ex; commit_exccode = code; commit_bd = bd;
        commit_pc = pc; commit_badvaddr = bva; commit_eret = er;
        mtc0_we = we; mtc0_addr = addr; mtc0_wdata = wd;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        mfc0_addr = a;
        #1;
        d = mfc0_rdata;
    endtask

    // ---------------- reference model (whole-register words) ----------------
    logic [31:0] m_status, m_cause, m_epc, m_bva, m_count, m_compare;
    logic        m_ti;
    logic [5:0]  m_ip;
    logic [5:0]  m_hist[$];
`ifdef CP0_TIMER_EN
    int unsigned m_div;
`endif

    task automatic m_reset();
        m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_bva = 0;
        m_count = 0; m_compare = 0; m_ti = 0; m_ip = 0;
`ifdef CP0_TIMER_EN
        m_div = 0;
`endif
        m_hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(6'd0);
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        logic [31:0] ca;
        ca = m_cause | {1'b0, m_ti, 30'd0} | {16'd0, m_ip[5] | m_ti, m_ip[4:0], 10'd0};
        case (a)
            8'h40:   return m_bva;
            8'h48:   return m_count;
            8'h58:   return m_compare;
            8'h60:   return m_status;
            8'h68:   return ca;
            8'h70:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_int();
        logic [31:0] ca;
        ca = m_read(8'h68);
        return (|(ca[15:8] & m_status[15:8])) & m_status[0] & ~m_status[1];
    endfunction

    task automatic m_edge();
        logic tint, tex, der, mok;
        logic [4:0] code;
        tint = commit_valid & m_int();
        tex  = commit_valid & (commit_ex | tint);
        code = tint ? 5'h00 : commit_exccode;
        der  = commit_valid & commit_eret & ~tex;
        mok  = commit_valid & mtc0_we & ~tex;
        if (tex) begin
            if (!m_status[1]) begin
                m_epc = commit_bd ? commit_pc - 32'd4 : commit_pc;
                m_cause[31] = commit_bd;
            end
            m_cause[6:2] = code;
            m_status[1] = 1'b1;
            if (code == 5'h04 || code == 5'h05) m_bva = commit_badvaddr;
        end
        if (mok) begin
            case (mtc0_addr)
                8'h60: m_status = (m_status & ~32'h0000_ff03) | (mtc0_wdata & 32'h0000_ff03);
                8'h68: m_cause[9:8] = mtc0_wdata[9:8];
                8'h70: m_epc = mtc0_wdata;
                default: ;
            endcase
        end
        if (der) m_status[1] = 1'b0;
`ifdef CP0_TIMER_EN
        if (mok && mtc0_addr == 8'h48) begin
            m_count = mtc0_wdata;
            m_div = 0;
        end else if (m_div == COUNT_DIV - 1) begin
            m_count = m_count + 32'd1;
            m_div = 0;
            if (m_count == m_compare) m_ti = 1'b1;
        end else begin
            m_div++;
        end
        if (mok && mtc0_addr == 8'h58) begin
            m_compare = mtc0_wdata;
            m_ti = 1'b0;
        end
`endif
        m_ip = m_hist.pop_front();
        m_hist.push_back(ext_int);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic v; logic ex; logic [4:0] code; logic bd; logic [31:0] pc; logic [31:0] bva;
        logic er; logic we; logic [7:0] addr; logic [31:0] wd;
        logic x_flush; logic [31:0] x_fpc; logic x_int;
        logic [31:0] x_epc; logic [31:0] x_cause; logic [31:0] x_status; logic [31:0] x_bva;
    } vec_t;

    vec_t tbl[18];
    logic [7:0] addrs[8];

    initial begin
        logic [31:0] d, prev_epc;
        logic exp_flush, tint, tex, der;
        logic [31:0] exp_fpc;

        tbl[0]  = '{1, 1, 5'h04, 1, 32'hbfc00104, 32'h3, 0, 0, 8'h00, 32'h0,
                    1, VEC, 0, 32'hbfc00100, 32'h80000010, 32'h00400002, 32'h3};
        tbl[1]  = '{1, 1, 5'h0c, 0, 32'h1000, 32'h55, 0, 0, 8'h00, 32'h0,
                    1, VEC, 0, 32'hbfc00100, 32'h80000030, 32'h00400002, 32'h3};
        tbl[2]  = '{1, 1, 5'h05, 0, 32'h2000, 32'hdead, 0, 0, 8'h00, 32'h0,
                    1, VEC, 0, 32'hbfc00100, 32'h80000014, 32'h00400002, 32'hdead};
        tbl[3]  = '{1, 0, 5'h00, 0, 32'h2004, 32'h0, 0, 1, A_EPC, 32'hbfc00200,
                    0, VEC, 0, 32'hbfc00200, 32'h80000014, 32'h00400002, 32'hdead};
        tbl[4]  = '{1, 0, 5'h00, 0, 32'h0, 32'h0, 1, 0, 8'h00, 32'h0,
                    1, 32'hbfc00200, 0, 32'hbfc00200, 32'h80000014, 32'h00400000, 32'hdead};
        tbl[5]  = '{1, 1, 5'h0a, 0, 32'h3000, 32'h0, 1, 0, 8'h00, 32'h0,
                    1, VEC, 0, 32'h3000, 32'h00000028, 32'h00400002, 32'hdead};
        tbl[6]  = '{1, 1, 5'h09, 1, 32'h4000, 32'h0, 1, 0, 8'h00, 32'h0,
                    1, VEC, 0, 32'h3000, 32'h00000024, 32'h00400002, 32'hdead};
        tbl[7]  = '{1, 1, 5'h08, 0, 32'h5000, 32'h0, 0, 1, A_ST, 32'hffffffff,
                    1, VEC, 0, 32'h3000, 32'h00000020, 32'h00400002, 32'hdead};
        tbl[8]  = '{1, 0, 5'h00, 0, 32'h0, 32'h0, 1, 1, A_ST, 32'h00000402,
                    1, 32'h3000, 0, 32'h3000, 32'h00000020, 32'h00400400, 32'hdead};
        tbl[9]  = '{0, 1, 5'h04, 0, 32'h9000, 32'h1234, 0, 1, A_EPC, 32'h1,
                    0, VEC, 0, 32'h3000, 32'h00000020, 32'h00400400, 32'hdead};
        tbl[10] = '{1, 0, 5'h00, 0, 32'h0, 32'h0, 0, 1, A_CA, 32'hffffffff,
                    0, VEC, 0, 32'h3000, 32'h00000320, 32'h00400400, 32'hdead};
        tbl[11] = '{1, 0, 5'h00, 0, 32'h0, 32'h0, 0, 1, 8'h61, 32'hffffffff,
                    0, VEC, 0, 32'h3000, 32'h00000320, 32'h00400400, 32'hdead};
        tbl[12] = '{1, 0, 5'h00, 0, 32'h0, 32'h0, 0, 1, A_CA, 32'h0,
                    0, VEC, 0, 32'h3000, 32'h00000020, 32'h00400400, 32'hdead};
        tbl[13] = '{1, 0, 5'h00, 0, 32'h0, 32'h0, 0, 1, A_ST, 32'h0000ff01,
                    0, VEC, 0, 32'h3000, 32'h00000020, 32'h0040ff01, 32'hdead};
        tbl[14] = '{1, 0, 5'h00, 0, 32'h0, 32'h0, 0, 1, A_CA, 32'h00000100,
                    0, VEC, 0, 32'h3000, 32'h00000120, 32'h0040ff01, 32'hdead};
        tbl[15] = '{1, 1, 5'h04, 0, 32'h6000, 32'h77, 0, 0, 8'h00, 32'h0,
                    1, VEC, 1, 32'h6000, 32'h00000100, 32'h0040ff03, 32'hdead};
        tbl[16] = '{1, 0, 5'h00, 0, 32'h0, 32'h0, 0, 1, A_CA, 32'h0,
                    0, VEC, 0, 32'h6000, 32'h00000000, 32'h0040ff03, 32'hdead};
        tbl[17] = '{1, 0, 5'h00, 0, 32'h0, 32'h0, 0, 1, A_ST, 32'h0,
                    0, VEC, 0, 32'h6000, 32'h00000000, 32'h00400000, 32'hdead};
        addrs = '{A_BVA, A_CNT, A_CMP, A_ST, A_CA, A_EPC, 8'h61, 8'h00};

        idle();
        mfc0_addr = 0;
        #25;
        tick();
        resetn = 1;

        // Reset state
        rd(A_ST, d);  check("reset status", d, 32'h0040_0000);
        rd(A_CA, d);  check("reset cause", d, 32'h0);
        rd(A_CNT, d); check("reset count", d, 32'h0);
        rd(8'h61, d); check("unmapped read", d, 32'h0);
        check("reset flush", flush, 1'b0);
        check("reset flush_pc", flush_pc, VEC);
        check("reset int_pending", int_pending, 1'b0);

        prev_epc = 32'h0;
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].ex, tbl[i].code, tbl[i].bd, tbl[i].pc, tbl[i].bva,
                  tbl[i].er, tbl[i].we, tbl[i].addr, tbl[i].wd);
            #1;
            check($sformatf("t%0d flush", i), flush, tbl[i].x_flush);
            check($sformatf("t%0d flush_pc", i), flush_pc, tbl[i].x_fpc);
            check($sformatf("t%0d int_pending", i), int_pending, tbl[i].x_int);
            rd(A_EPC, d); check($sformatf("t%0d epc pre-edge", i), d, prev_epc);
            tick();
            idle();
            rd(A_EPC, d); check($sformatf("t%0d epc", i), d, tbl[i].x_epc);
            rd(A_CA, d);  check($sformatf("t%0d cause", i), d, tbl[i].x_cause);
            rd(A_ST, d);  check($sformatf("t%0d status", i), d, tbl[i].x_status);
            rd(A_BVA, d); check($sformatf("t%0d badvaddr", i), d, tbl[i].x_bva);
            prev_epc = tbl[i].x_epc;
        end

        // External interrupt through the synchroniser
        drive(1, 0, 0, 0, 0, 0, 0, 1, A_ST, 32'h0000_0401);
        tick();
        idle();
        ext_int = 6'b000001;
        #1;
        check("ext int latency 0", int_pending, 1'b0);
        for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
            tick();
            check($sformatf("ext int latency %0d", k), int_pending, k == SYNC_STAGES + 1);
        end
        rd(A_CA, d); check("ext int cause ip2", d, 32'h0000_0400);
        drive(1, 0, 0, 0, 32'h7000, 0, 0, 0, 0, 0);
        #1;
        check("int take flush", flush, 1'b1);
        check("int take flush_pc", flush_pc, VEC);
        tick();
        idle();
        rd(A_EPC, d); check("int epc", d, 32'h7000);
        rd(A_CA, d);  check("int cause", d, 32'h0000_0400);
        rd(A_ST, d);  check("int status", d, 32'h0040_0403);
        check("int pending after take", int_pending, 1'b0);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        check("int eret flush_pc", flush_pc, 32'h7000);
        tick();
        idle();
        check("int pending after eret", int_pending, 1'b1);

        // Asynchronous reset mid-cycle, no clock edge
        commit_valid = 1;
        #2;
        resetn = 0;
        #1;
        check("async rst int_pending", int_pending, 1'b0);
        check("async rst flush", flush, 1'b0);
        check("async rst flush_pc", flush_pc, VEC);
        rd(A_ST, d);  check("async rst status", d, 32'h0040_0000);
        rd(A_CA, d);  check("async rst cause", d, 32'h0);
        rd(A_EPC, d); check("async rst epc", d, 32'h0);
        rd(A_BVA, d); check("async rst badvaddr", d, 32'h0);
        idle();
        ext_int = 0;
        tick();
        resetn = 1;
        tick();

`ifdef CP0_TIMER_EN
        drive(1, 0, 0, 0, 0, 0, 0, 1, A_CMP, 32'd5);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 1, A_CNT, 32'd0);
        tick();
        idle();
        for (int k = 1; k <= 10; k++) begin
            tick();
            rd(A_CNT, d); check($sformatf("timer count %0d", k), d, k / 2);
            rd(A_CA, d);  check($sformatf("timer ti %0d", k), d[30], k == 10);
        end
        check("timer cause", d, 32'h4000_8000);
        drive(1, 0, 0, 0, 0, 0, 0, 1, A_CMP, 32'h100);
        rd(A_CA, d); check("timer cause pre-clear", d, 32'h4000_8000);
        tick();
        idle();
        rd(A_CA, d);  check("timer ti cleared", d, 32'h0);
        rd(A_CMP, d); check("timer compare", d, 32'h100);
`else
        drive(1, 0, 0, 0, 0, 0, 0, 1, A_CNT, 32'h1234);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 1, A_CMP, 32'd5);
        tick();
        idle();
        rd(A_CNT, d); check("no timer count", d, 32'h0);
        rd(A_CMP, d); check("no timer compare", d, 32'h0);
        repeat (12) tick();
        rd(A_CA, d); check("no timer cause", d, 32'h0);
`endif

        // Randomized run against the reference model
        resetn = 0;
        idle();
        ext_int = 0;
        #3;
        tick();
        m_reset();
        resetn = 1;
        for (int c = 0; c < 3000; c++) begin
            commit_valid    = ($urandom_range(0, 9) < 7);
            commit_ex       = ($urandom_range(0, 7) == 0);
            commit_exccode  = 5'($urandom);
            commit_bd       = 1'($urandom);
            commit_pc       = $urandom & 32'hffff_fffc;
            commit_badvaddr = $urandom;
            commit_eret     = ($urandom_range(0, 7) == 0);
            mtc0_we         = ($urandom_range(0, 2) == 0);
            mtc0_addr       = addrs[$urandom_range(0, 7)];
            mtc0_wdata      = (mtc0_addr == A_CNT || mtc0_addr == A_CMP) ?
                              32'($urandom_range(0, 20)) : $urandom;
            if ($urandom_range(0, 15) == 0) ext_int = 6'($urandom);
            mfc0_addr = addrs[$urandom_range(0, 7)];
            #4;
            tint      = commit_valid & m_int();
            tex       = commit_valid & (commit_ex | tint);
            der       = commit_valid & commit_eret & ~tex;
            exp_flush = tex | der;
            exp_fpc   = der ? m_epc : VEC;
            check($sformatf("rnd%0d int_pending", c), int_pending, m_int());
            check($sformatf("rnd%0d flush", c), flush, exp_flush);
            check($sformatf("rnd%0d flush_pc", c), flush_pc, exp_fpc);
            check($sformatf("rnd%0d mfc0 %02h", c, mfc0_addr), mfc0_rdata, m_read(mfc0_addr));
            m_edge();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
